// File: rtl/uart_bus_bridge.sv
// UART-to-bus debug initiator: decodes read/write command frames from the rx byte
// stream, runs one bus transaction as master and returns ACK/NAK plus read data.
module uart_bus_bridge #(
    parameter int BUS_TIMEOUT   = 256,
    parameter int FRAME_TIMEOUT = 65536
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_end,
    input  logic [7:0]  rx_data,
    input  logic        tx_busy,
    input  logic        tx_end,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    output logic        m_req_,
    input  logic        m_grnt_,
    output logic [29:0] m_addr,
    output logic        m_as_,
    output logic        m_rw,
    output logic [31:0] m_wr_data,
    input  logic [31:0] m_rd_data,
    input  logic        m_rdy_,
    output logic        busy
);
    // state    | meaning
    // IDLE     | waiting for a command byte
    // ADDR     | collecting 4 address bytes, MSB first
    // DATA     | collecting 4 write-data bytes, MSB first
    // BUS_REQ  | requesting the bus, waiting for grant
    // BUS_ACC  | one-cycle address strobe
    // BUS_WAIT | waiting for slave ready
    // RESP     | waiting for transmitter idle, then launching one byte
    // TX_WAIT  | waiting for the byte to finish

    localparam int BTW = $clog2(BUS_TIMEOUT);
    localparam int FTW = $clog2(FRAME_TIMEOUT);
    localparam logic [7:0] CMD_WR  = 8'h57;
    localparam logic [7:0] CMD_RD  = 8'h52;
    localparam logic [7:0] RSP_ACK = 8'h06;
    localparam logic [7:0] RSP_NAK = 8'h15;

    typedef enum logic [2:0] {
        IDLE, ADDR, DATA, BUS_REQ, BUS_ACC, BUS_WAIT, RESP, TX_WAIT
    } state_t;

    state_t         state_q, state_d;
    logic [1:0]     cnt_q, cnt_d;
    logic [2:0]     idx_q, idx_d;
    logic [29:0]    addr_q, addr_d;
    logic [31:0]    wdata_q, wdata_d;
    logic [31:0]    rdata_q, rdata_d;
    logic           rw_q, rw_d;
    logic           nak_q, nak_d;
    logic           tx_start_q, tx_start_d;
    logic [7:0]     tx_data_q, tx_data_d;
    logic [BTW-1:0] btmr_q, btmr_d;
    logic [FTW-1:0] ftmr_q, ftmr_d;
    logic [7:0]     resp_byte;
    logic           last_byte;
    logic           bus_state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            rw_q       <= 1'b1;
            nak_q      <= 1'b0;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
            btmr_q     <= '0;
            ftmr_q     <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            rw_q       <= rw_d;
            nak_q      <= nak_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
            btmr_q     <= btmr_d;
            ftmr_q     <= ftmr_d;
        end
    end

    assign bus_state = (state_q == BUS_REQ) || (state_q == BUS_ACC) || (state_q == BUS_WAIT);

    always_comb begin
        resp_byte = 8'h00;
        case (idx_q)
            3'd0:    resp_byte = nak_q ? RSP_NAK : RSP_ACK;
            3'd1:    resp_byte = rdata_q[31:24];
            3'd2:    resp_byte = rdata_q[23:16];
            3'd3:    resp_byte = rdata_q[15:8];
            3'd4:    resp_byte = rdata_q[7:0];
            default: resp_byte = 8'h00;
        endcase
    end

    // A NAK or write ACK is a single byte; a read returns ACK plus four data bytes.
    assign last_byte = nak_q || !rw_q || (idx_q == 3'd4);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        rw_d       = rw_q;
        nak_d      = nak_q;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;
        btmr_d     = bus_state ? btmr_q - BTW'(1) : btmr_q;
        ftmr_d     = ftmr_q;

        case (state_q)
            IDLE: begin
                if (rx_end && (rx_data == CMD_WR || rx_data == CMD_RD)) begin
                    rw_d    = (rx_data == CMD_RD);
                    cnt_d   = 2'd0;
                    ftmr_d  = FTW'(FRAME_TIMEOUT - 1);
                    state_d = ADDR;
                end
            end
            ADDR: begin
                if (rx_end) begin
                    addr_d = {addr_q[21:0], rx_data};
                    cnt_d  = cnt_q + 2'd1;
                    ftmr_d = FTW'(FRAME_TIMEOUT - 1);
                    if (cnt_q == 2'd3)
                        state_d = rw_q ? BUS_REQ : DATA;
                end else if (ftmr_q == '0) begin
                    state_d = IDLE;
                end else begin
                    ftmr_d = ftmr_q - FTW'(1);
                end
            end
            DATA: begin
                if (rx_end) begin
                    wdata_d = {wdata_q[23:0], rx_data};
                    cnt_d   = cnt_q + 2'd1;
                    ftmr_d  = FTW'(FRAME_TIMEOUT - 1);
                    if (cnt_q == 2'd3)
                        state_d = BUS_REQ;
                end else if (ftmr_q == '0) begin
                    state_d = IDLE;
                end else begin
                    ftmr_d = ftmr_q - FTW'(1);
                end
            end
            BUS_REQ: begin
                if (btmr_q == '0) begin
                    nak_d   = 1'b1;
                    idx_d   = 3'd0;
                    state_d = RESP;
                end else if (!m_grnt_) begin
                    state_d = BUS_ACC;
                end
            end
            BUS_ACC: begin
                if (btmr_q == '0) begin
                    nak_d   = 1'b1;
                    idx_d   = 3'd0;
                    state_d = RESP;
                end else begin
                    state_d = BUS_WAIT;
                end
            end
            BUS_WAIT: begin
                // A ready on the last counted cycle still wins over the timeout.
                if (!m_rdy_) begin
                    rdata_d = m_rd_data;
                    nak_d   = 1'b0;
                    idx_d   = 3'd0;
                    state_d = RESP;
                end else if (btmr_q == '0) begin
                    nak_d   = 1'b1;
                    idx_d   = 3'd0;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (!tx_busy) begin
                    tx_start_d = 1'b1;
                    tx_data_d  = resp_byte;
                    state_d    = TX_WAIT;
                end
            end
            TX_WAIT: begin
                if (tx_end) begin
                    if (last_byte) begin
                        state_d = IDLE;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        state_d = RESP;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_d == BUS_REQ && state_q != BUS_REQ) begin
            btmr_d = BTW'(BUS_TIMEOUT - 1);
            nak_d  = 1'b0;
        end
    end

    assign m_req_    = !bus_state;
    assign m_as_     = (state_q != BUS_ACC);
    assign m_addr    = addr_q;
    assign m_rw      = rw_q;
    assign m_wr_data = wdata_q;
    assign tx_start  = tx_start_q;
    assign tx_data   = tx_data_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_bus_bridge.sv
// Scoreboarded bench for uart_bus_bridge: host frames in, bus slave and uart
// transmitter models out; expected bus cycles and tx bytes are queued at stimulus time.
module tb_uart_bus_bridge;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        rx_end = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        tx_busy = 1'b0;
    logic        tx_end = 1'b0;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        m_req_;
    logic        m_grnt_ = 1'b1;
    logic [29:0] m_addr;
    logic        m_as_;
    logic        m_rw;
    logic [31:0] m_wr_data;
    logic [31:0] m_rd_data = 32'h0;
    logic        m_rdy_ = 1'b1;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0]  exp_tx[$];
    logic [29:0] exp_addr[$];
    logic        exp_rw[$];
    logic [31:0] exp_wd[$];

    logic        grant_en = 1'b1;
    logic        rdy_en = 1'b1;
    int          tx_cnt = 0;
    int          req_run = 0;
    int          last_req_run = 0;
    int          req_low_total = 0;
    int          as_run = 0;
    int          as_count = 0;
    logic        as_pend = 1'b0;
    logic [29:0] cur_addr = '0;

    uart_bus_bridge dut (
        .clk       (clk),
        .reset     (reset),
        .rx_end    (rx_end),
        .rx_data   (rx_data),
        .tx_busy   (tx_busy),
        .tx_end    (tx_end),
        .tx_start  (tx_start),
        .tx_data   (tx_data),
        .m_req_    (m_req_),
        .m_grnt_   (m_grnt_),
        .m_addr    (m_addr),
        .m_as_     (m_as_),
        .m_rw      (m_rw),
        .m_wr_data (m_wr_data),
        .m_rd_data (m_rd_data),
        .m_rdy_    (m_rdy_),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Transmitter model: byte takes 12 cycles, then a one-cycle tx_end.
    initial begin
        forever begin
            tick();
            tx_end = 1'b0;
            if (tx_start) begin
                chk("tx_start_while_busy", {31'b0, tx_busy}, 32'd0);
                chk("tx_expected", {31'b0, exp_tx.size() != 0}, 32'd1);
                if (exp_tx.size() != 0)
                    chk("tx_data", {24'b0, tx_data}, {24'b0, exp_tx.pop_front()});
                tx_busy = 1'b1;
                tx_cnt  = 12;
            end else if (tx_cnt > 0) begin
                tx_cnt--;
                if (tx_cnt == 0) begin
                    tx_busy = 1'b0;
                    tx_end  = 1'b1;
                end
            end
        end
    end

    // Bus slave/arbiter model: grant after two request cycles, ready one cycle after strobe.
    initial begin
        logic [29:0] ea;
        logic        erw;
        logic [31:0] ewd;
        forever begin
            tick();
            m_rdy_ = 1'b1;
            if (as_pend) begin
                if (rdy_en) begin
                    m_rdy_ = 1'b0;
                    chk("m_addr_hold", {2'b0, m_addr}, {2'b0, cur_addr});
                end
                as_pend = 1'b0;
            end
            if (!m_req_) begin
                req_run++;
                req_low_total++;
            end else begin
                if (req_run != 0) last_req_run = req_run;
                req_run = 0;
            end
            m_grnt_ = !(grant_en && !m_req_ && req_run >= 2);
            if (!m_as_) begin
                as_run++;
                if (as_run == 1) begin
                    as_count++;
                    as_pend = 1'b1;
                    chk("bus_expected", {31'b0, exp_addr.size() != 0}, 32'd1);
                    if (exp_addr.size() != 0) begin
                        ea  = exp_addr.pop_front();
                        erw = exp_rw.pop_front();
                        ewd = exp_wd.pop_front();
                        cur_addr = ea;
                        chk("m_addr", {2'b0, m_addr}, {2'b0, ea});
                        chk("m_rw", {31'b0, m_rw}, {31'b0, erw});
                        chk("m_req_at_as", {31'b0, m_req_}, 32'd0);
                        if (!erw) chk("m_wr_data", m_wr_data, ewd);
                    end
                end
            end else if (as_run != 0) begin
                chk("as_width", as_run, 32'd1);
                as_run = 0;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        tick();
        rx_data = b;
        rx_end  = 1'b1;
        tick();
        rx_end  = 1'b0;
        repeat (2) tick();
    endtask

    task automatic send_rd(input logic [31:0] a);
        send_byte(8'h52);
        for (int i = 3; i >= 0; i--) send_byte(a[8*i +: 8]);
    endtask

    task automatic send_wr(input logic [31:0] a, input logic [31:0] d);
        send_byte(8'h57);
        for (int i = 3; i >= 0; i--) send_byte(a[8*i +: 8]);
        for (int i = 3; i >= 0; i--) send_byte(d[8*i +: 8]);
    endtask

    task automatic push_bus(input logic [29:0] a, input logic rw, input logic [31:0] d);
        exp_addr.push_back(a);
        exp_rw.push_back(rw);
        exp_wd.push_back(d);
    endtask

    task automatic push_read_resp(input logic [31:0] d);
        exp_tx.push_back(8'h06);
        for (int i = 3; i >= 0; i--) exp_tx.push_back(d[8*i +: 8]);
    endtask

    task automatic wait_done(input string tag, input int maxc);
        int n = 0;
        while ((busy || tx_busy || exp_tx.size() != 0) && n < maxc) begin
            tick();
            n++;
        end
        chk({tag, "_done"}, {31'b0, !(busy || tx_busy || exp_tx.size() != 0)}, 32'd1);
        chk({tag, "_bus_left"}, exp_addr.size(), 32'd0);
    endtask

    initial begin
        int start;
        int n;

        #1 reset = 1'b1;
        #1;
        chk("rst_m_req_", {31'b0, m_req_}, 32'd1);
        chk("rst_m_as_", {31'b0, m_as_}, 32'd1);
        chk("rst_m_rw", {31'b0, m_rw}, 32'd1);
        chk("rst_m_addr", {2'b0, m_addr}, 32'd0);
        chk("rst_m_wr_data", m_wr_data, 32'd0);
        chk("rst_tx_start", {31'b0, tx_start}, 32'd0);
        chk("rst_tx_data", {24'b0, tx_data}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        repeat (3) tick();
        reset = 1'b0;
        repeat (2) tick();

        // write
        push_bus(30'h100, 1'b0, 32'hDEADBEEF);
        exp_tx.push_back(8'h06);
        send_wr(32'h0000_0100, 32'hDEADBEEF);
        wait_done("write", 400);

        // read
        m_rd_data = 32'h12345678;
        push_bus(30'h40, 1'b1, 32'h0);
        push_read_resp(32'h12345678);
        send_rd(32'h0000_0040);
        wait_done("read", 600);

        // unknown command, then a read whose address has bits 31:30 set
        send_byte(8'h41);
        repeat (3) tick();
        chk("badcmd_busy", {31'b0, busy}, 32'd0);
        m_rd_data = 32'hA5C30F96;
        push_bus(30'h44, 1'b1, 32'h0);
        push_read_resp(32'hA5C30F96);
        send_rd(32'hC000_0044);
        wait_done("badcmd_read", 600);

        // bus timeout
        grant_en = 1'b0;
        start = as_count;
        exp_tx.push_back(8'h15);
        send_wr(32'h0000_0008, 32'h11223344);
        wait_done("bus_tmo", 600);
        chk("bus_tmo_req_cycles", last_req_run, 32'd256);
        chk("bus_tmo_no_as", as_count - start, 32'd0);
        grant_en = 1'b1;

        // frame timeout
        start = req_low_total;
        send_byte(8'h57);
        send_byte(8'h00);
        repeat (65000) tick();
        chk("frame_tmo_still_busy", {31'b0, busy}, 32'd1);
        repeat (600) tick();
        chk("frame_tmo_idle", {31'b0, busy}, 32'd0);
        chk("frame_tmo_no_req", req_low_total - start, 32'd0);
        push_bus(30'h10, 1'b0, 32'hCAFEF00D);
        exp_tx.push_back(8'h06);
        send_wr(32'h0000_0010, 32'hCAFEF00D);
        wait_done("after_frame_tmo", 400);

        // asynchronous reset while stalled in BUS_WAIT
        rdy_en = 1'b0;
        start = as_count;
        push_bus(30'h7C, 1'b1, 32'h0);
        send_rd(32'h0000_007C);
        n = 0;
        while (as_count == start && n < 100) begin
            tick();
            n++;
        end
        chk("reach_bus_wait", as_count - start, 32'd1);
        repeat (4) @(posedge clk);
        #3;
        chk("pre_rst_m_req_", {31'b0, m_req_}, 32'd0);
        chk("pre_rst_busy", {31'b0, busy}, 32'd1);
        reset = 1'b1;
        #1;
        chk("async_rst_m_req_", {31'b0, m_req_}, 32'd1);
        chk("async_rst_m_as_", {31'b0, m_as_}, 32'd1);
        chk("async_rst_busy", {31'b0, busy}, 32'd0);
        chk("async_rst_m_addr", {2'b0, m_addr}, 32'd0);
        tick();
        reset = 1'b0;
        rdy_en = 1'b1;
        repeat (2) tick();

        m_rd_data = 32'h0BADF00D;
        push_bus(30'h20, 1'b1, 32'h0);
        push_read_resp(32'h0BADF00D);
        send_rd(32'h0000_0020);
        wait_done("after_reset", 600);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
